// File: rtl/audio_mixer_sd.sv
// Stereo N-channel audio mixer (time-multiplexed MAC, saturating) feeding two first-order
// sigma-delta 1-bit DACs. Define MIXER_DITHER_EN to add LFSR dither at the DAC inputs.
module audio_mixer_sd #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned IW         = 8,
    parameter int unsigned GW         = 4,
    parameter int unsigned OW         = 12,
    parameter int unsigned SHIFT      = 1,
    parameter int unsigned SAMPLE_DIV = 64
) (
    input  logic              clkdac,
    input  logic              reset_n,
    input  logic [NCH*IW-1:0] ch_in,
    input  logic [NCH*GW-1:0] ch_gain,
    input  logic [NCH-1:0]    ch_left_en,
    input  logic [NCH-1:0]    ch_right_en,
    output logic [OW-1:0]     mix_l,
    output logic [OW-1:0]     mix_r,
    output logic              sample_strobe,
    output logic              clip_l,
    output logic              clip_r,
    output logic              audio_l,
    output logic              audio_r
);

    localparam int unsigned PW   = IW + GW;
    localparam int unsigned AW   = PW + $clog2(NCH) + 1;
    localparam int unsigned SW   = (AW > OW) ? AW : OW + 1;
    localparam int unsigned CW   = $clog2(SAMPLE_DIV);
    localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [CW-1:0]   CNT_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCH - 1);
    localparam logic [SW-1:0]   MIX_MAX  = {{(SW - OW){1'b0}}, {OW{1'b1}}};

    typedef enum logic [1:0] {StIdle, StSnap, StAccum, StSat} state_e;

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    logic [IDXW-1:0] r_idx;
    logic [IW-1:0]   r_snap_in   [NCH];
    logic [GW-1:0]   r_snap_gain [NCH];
    logic [NCH-1:0]  r_snap_l;
    logic [NCH-1:0]  r_snap_r;
    logic [AW-1:0]   r_acc_l;
    logic [AW-1:0]   r_acc_r;
    logic [OW-1:0]   r_mix_l;
    logic [OW-1:0]   r_mix_r;
    logic            r_strobe;
    logic            r_clip_l;
    logic            r_clip_r;

    logic            w_snap;
    logic [PW-1:0]   w_prod;
    logic [SW-1:0]   w_shift_l;
    logic [SW-1:0]   w_shift_r;

    // The first edge after reset is counter cycle 0, so IDLE at count 0 also snapshots.
    assign w_snap    = (r_state == StSnap) || ((r_state == StIdle) && (r_cnt == '0));
    assign w_prod    = PW'(r_snap_in[r_idx]) * PW'(r_snap_gain[r_idx]);
    assign w_shift_l = SW'(r_acc_l) >> SHIFT;
    assign w_shift_r = SW'(r_acc_r) >> SHIFT;

    always_ff @(posedge clkdac or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_mix_l  <= '0;
            r_mix_r  <= '0;
            r_strobe <= 1'b0;
            r_clip_l <= 1'b0;
            r_clip_r <= 1'b0;
        end else begin
            r_cnt    <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            r_strobe <= 1'b0;
            r_clip_l <= 1'b0;
            r_clip_r <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (r_cnt == '0) begin
                        r_idx   <= '0;
                        r_state <= StAccum;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= StSnap;
                    end
                end
                StSnap: begin
                    r_idx   <= '0;
                    r_state <= StAccum;
                end
                StAccum: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == IDX_LAST) r_state <= StSat;
                end
                StSat: begin
                    r_strobe <= 1'b1;
                    r_state  <= StIdle;
                    if (w_shift_l > MIX_MAX) begin
                        r_mix_l  <= '1;
                        r_clip_l <= 1'b1;
                    end else begin
                        r_mix_l <= w_shift_l[OW-1:0];
                    end
                    if (w_shift_r > MIX_MAX) begin
                        r_mix_r  <= '1;
                        r_clip_r <= 1'b1;
                    end else begin
                        r_mix_r <= w_shift_r[OW-1:0];
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clkdac or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_snap_in[i]   <= '0;
                r_snap_gain[i] <= '0;
            end
            r_snap_l <= '0;
            r_snap_r <= '0;
            r_acc_l  <= '0;
            r_acc_r  <= '0;
        end else if (w_snap) begin
            for (int i = 0; i < NCH; i++) begin
                r_snap_in[i]   <= ch_in[i*IW +: IW];
                r_snap_gain[i] <= ch_gain[i*GW +: GW];
            end
            r_snap_l <= ch_left_en;
            r_snap_r <= ch_right_en;
            r_acc_l  <= '0;
            r_acc_r  <= '0;
        end else if (r_state == StAccum) begin
            if (r_snap_l[r_idx]) r_acc_l <= r_acc_l + AW'(w_prod);
            if (r_snap_r[r_idx]) r_acc_r <= r_acc_r + AW'(w_prod);
        end
    end

    logic [OW-1:0] w_dac_l;
    logic [OW-1:0] w_dac_r;

`ifdef MIXER_DITHER_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    // Right-shifting form of taps 16,14,13,11.
    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    always_ff @(posedge clkdac or negedge reset_n) begin
        if (!reset_n) r_lfsr <= 16'hACE1;
        else          r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end

    assign w_dac_l = (&r_mix_l) ? r_mix_l : r_mix_l + OW'(r_lfsr[0]);
    assign w_dac_r = (&r_mix_r) ? r_mix_r : r_mix_r + OW'(r_lfsr[8]);
`else
    assign w_dac_l = r_mix_l;
    assign w_dac_r = r_mix_r;
`endif

    logic [OW+1:0] r_sig_l;
    logic [OW+1:0] r_sig_r;
    logic [OW+1:0] w_delta_l;
    logic [OW+1:0] w_delta_r;
    logic          r_audio_l;
    logic          r_audio_r;

    // Sign-extended MSB feedback subtracts 2^OW whenever the integrator is above midscale.
    assign w_delta_l = {2'b00, w_dac_l} + {r_sig_l[OW+1], r_sig_l[OW+1], {OW{1'b0}}};
    assign w_delta_r = {2'b00, w_dac_r} + {r_sig_r[OW+1], r_sig_r[OW+1], {OW{1'b0}}};

    always_ff @(posedge clkdac or negedge reset_n) begin
        if (!reset_n) begin
            r_sig_l   <= {2'b01, {OW{1'b0}}};
            r_sig_r   <= {2'b01, {OW{1'b0}}};
            r_audio_l <= 1'b0;
            r_audio_r <= 1'b0;
        end else begin
            r_sig_l   <= r_sig_l + w_delta_l;
            r_sig_r   <= r_sig_r + w_delta_r;
            r_audio_l <= r_sig_l[OW+1];
            r_audio_r <= r_sig_r[OW+1];
        end
    end

    assign mix_l         = r_mix_l;
    assign mix_r         = r_mix_r;
    assign sample_strobe = r_strobe;
    assign clip_l        = r_clip_l;
    assign clip_r        = r_clip_r;
    assign audio_l       = r_audio_l;
    assign audio_r       = r_audio_r;

endmodule

// File: tb/tb_audio_mixer_sd.sv
// Self-checking bench for audio_mixer_sd (default build): frame timing, mix arithmetic,
// clipping, snapshot semantics, mid-frame reset and sigma-delta ones density.
module tb_audio_mixer_sd;

    localparam int NCH = 4;
    localparam int IW  = 8;
    localparam int GW  = 4;
    localparam int OW  = 12;
    localparam int DIV = 64;
    localparam int MAXMIX = (1 << OW) - 1;

    logic              clkdac = 1'b0;
    logic              reset_n = 1'b0;
    logic [NCH*IW-1:0] ch_in = '0;
    logic [NCH*GW-1:0] ch_gain = '0;
    logic [NCH-1:0]    ch_left_en = '0;
    logic [NCH-1:0]    ch_right_en = '0;
    logic [OW-1:0]     mix_l;
    logic [OW-1:0]     mix_r;
    logic              sample_strobe;
    logic              clip_l;
    logic              clip_r;
    logic              audio_l;
    logic              audio_r;

    audio_mixer_sd dut (
        .clkdac        (clkdac),
        .reset_n       (reset_n),
        .ch_in         (ch_in),
        .ch_gain       (ch_gain),
        .ch_left_en    (ch_left_en),
        .ch_right_en   (ch_right_en),
        .mix_l         (mix_l),
        .mix_r         (mix_r),
        .sample_strobe (sample_strobe),
        .clip_l        (clip_l),
        .clip_r        (clip_r),
        .audio_l       (audio_l),
        .audio_r       (audio_r)
    );

    always #5 clkdac = ~clkdac;

    // Rising edges since reset release; cycle k of a frame has cyc % DIV == k.
    int cyc;
    always @(posedge clkdac or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    int m_in[NCH];
    int m_gain[NCH];
    bit m_l[NCH];
    bit m_r[NCH];
    int exp_l, exp_r;
    bit exp_cl, exp_cr;
    int n_checks = 0;
    int n_err = 0;
    int last_strobe_cyc = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NCH; i++) begin
            ch_in[i*IW +: IW]   = m_in[i][IW-1:0];
            ch_gain[i*GW +: GW] = m_gain[i][GW-1:0];
            ch_left_en[i]       = m_l[i];
            ch_right_en[i]      = m_r[i];
        end
    endtask

    // Mix = min((sum of enabled in*gain) / 2, full scale).
    task automatic model();
        int sl, sr;
        sl = 0;
        sr = 0;
        for (int i = 0; i < NCH; i++) begin
            if (m_l[i]) sl += m_in[i] * m_gain[i];
            if (m_r[i]) sr += m_in[i] * m_gain[i];
        end
        sl = sl / 2;
        sr = sr / 2;
        exp_cl = (sl > MAXMIX);
        exp_cr = (sr > MAXMIX);
        exp_l  = exp_cl ? MAXMIX : sl;
        exp_r  = exp_cr ? MAXMIX : sr;
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < NCH; i++) begin
            m_in[i]   = int'($urandom_range(255, 0));
            m_gain[i] = int'($urandom_range(15, 0));
            m_l[i]    = 1'($urandom_range(1, 0));
            m_r[i]    = 1'($urandom_range(1, 0));
        end
    endtask

    task automatic wait_strobe(input string tag);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 2 * DIV && !found; k++) begin
            @(negedge clkdac);
            if (sample_strobe === 1'b1) found = 1'b1;
        end
        last_strobe_cyc = cyc;
        check({tag, "_strobe_seen"}, 32'(found), 32'd1);
    endtask

    task automatic frame_check(input string tag);
        wait_strobe(tag);
        check({tag, "_phase"}, 32'(cyc % DIV), 32'(NCH + 2));
        check({tag, "_mix_l"}, 32'(mix_l), 32'(exp_l));
        check({tag, "_mix_r"}, 32'(mix_r), 32'(exp_r));
        check({tag, "_clip"}, {30'd0, clip_l, clip_r}, {30'd0, exp_cl, exp_cr});
        @(negedge clkdac);
        check({tag, "_post_flags"}, {29'd0, sample_strobe, clip_l, clip_r}, 32'd0);
        check({tag, "_hold_l"}, 32'(mix_l), 32'(exp_l));
    endtask

    task automatic wait_phase(input int ph);
        for (int k = 0; k < DIV && (cyc % DIV) != ph; k++) @(negedge clkdac);
        check("wait_phase", 32'(cyc % DIV), 32'(ph));
    endtask

    initial begin
        int ones_l, ones_r, sa_l, sa_r;
        bit sa_cl, sa_cr;

        for (int i = 0; i < NCH; i++) begin
            m_in[i] = 0; m_gain[i] = 0; m_l[i] = 1'b0; m_r[i] = 1'b0;
        end
        drive();
        model();

        // Reset state
        repeat (3) @(negedge clkdac);
        check("reset_outputs", 32'({mix_l, mix_r, sample_strobe, clip_l, clip_r, audio_l, audio_r}),
              32'd0);
        reset_n = 1'b1;

        // Silent frames: strobes at 6 and 70, no DAC activity
        frame_check("silent0");
        check("first_strobe_cyc", 32'(last_strobe_cyc), 32'(NCH + 2));
        ones_l = 0;
        repeat (40) @(negedge clkdac) ones_l += int'(audio_l) + int'(audio_r);
        check("silent_audio", 32'(ones_l), 32'd0);
        frame_check("silent1");
        check("second_strobe_cyc", 32'(last_strobe_cyc), 32'(DIV + NCH + 2));

        // ch0 = 200 x 3 on left only -> 300
        m_in[0] = 200; m_gain[0] = 3; m_l[0] = 1'b1;
        drive();
        model();
        frame_check("mix300");
        ones_l = 0;
        ones_r = 0;
        repeat (4096) begin
            @(negedge clkdac);
            ones_l += int'(audio_l);
            ones_r += int'(audio_r);
        end
        n_checks++;
        assert (ones_l >= 299 && ones_l <= 301) else begin
            n_err++;
            $error("FAIL dens300: observed %0d expected 300+-1", ones_l);
        end
        check("dens_r_zero", 32'(ones_r), 32'd0);

        // Full scale on all channels, both sides -> clip
        wait_strobe("sync_sat");
        for (int i = 0; i < NCH; i++) begin
            m_in[i] = 255; m_gain[i] = 15; m_l[i] = 1'b1; m_r[i] = 1'b1;
        end
        drive();
        model();
        frame_check("sat");

        // Inputs changed during ACCUM take effect one frame later
        randomize_inputs();
        drive();
        model();
        sa_l = exp_l; sa_r = exp_r; sa_cl = exp_cl; sa_cr = exp_cr;
        wait_phase(2);
        randomize_inputs();
        drive();
        exp_l = sa_l; exp_r = sa_r; exp_cl = sa_cl; exp_cr = sa_cr;
        frame_check("snap_old");
        model();
        frame_check("snap_new");

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            randomize_inputs();
            drive();
            model();
            frame_check("rand");
        end

        // Reset at cycle 3 of a frame aborts it
        randomize_inputs();
        drive();
        model();
        wait_phase(3);
        reset_n = 1'b0;
        #1;
        check("midrst_outputs",
              32'({mix_l, mix_r, sample_strobe, clip_l, clip_r, audio_l, audio_r}), 32'd0);
        ones_l = 0;
        repeat (4) @(negedge clkdac) ones_l += int'(sample_strobe);
        check("midrst_no_strobe", 32'(ones_l), 32'd0);
        reset_n = 1'b1;
        frame_check("post_rst");
        check("post_rst_strobe_cyc", 32'(last_strobe_cyc), 32'(NCH + 2));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
